// File: rtl/stall_unit.sv
// stall_unit: GPR Tuse/Tnew hazard detection with E/M/W tag pipeline and stall control.
// Define MD_HAZARD_EN to add mult/div busy tracking (counter-based) to the stall decision.
module stall_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [1:0] tuse_rs_d,
  input  logic [1:0] tuse_rt_d,
  input  logic [4:0] wdst_d,
  input  logic [1:0] tnew_d,
  input  logic       md_use_d,
  input  logic       md_start_e,
  input  logic       md_kind_e,
  output logic       stall,
  output logic       en_pc,
  output logic       en_d,
  output logic       clr_e,
  output logic       md_busy,
  output logic [1:0] tnew_e,
  output logic [1:0] tnew_m
);
  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } tag_t;

  tag_t tagE, tagM, tagW;
  logic gprHaz, mdStall;

  function automatic logic hazard(input tag_t t, input logic [4:0] src, input logic [1:0] tuse);
    return (t.dst == src) && (src != 5'd0) && (tuse < t.tnew);
  endfunction

  // Tnew counts down as a tag moves to older stages and saturates at 0.
  function automatic tag_t age(input tag_t t);
    return {t.dst, (t.tnew == 2'd0) ? 2'd0 : t.tnew - 2'd1};
  endfunction

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tagE <= '0;
      tagM <= '0;
      tagW <= '0;
    end else begin
      tagE <= stall ? tag_t'('0) : {wdst_d, tnew_d};
      tagM <= age(tagE);
      tagW <= age(tagM);
    end

  assign gprHaz = hazard(tagE, rs_d, tuse_rs_d) | hazard(tagM, rs_d, tuse_rs_d) |
                  hazard(tagW, rs_d, tuse_rs_d) | hazard(tagE, rt_d, tuse_rt_d) |
                  hazard(tagM, rt_d, tuse_rt_d) | hazard(tagW, rt_d, tuse_rt_d);

`ifdef MD_HAZARD_EN
  logic [3:0] mdCnt;

  always_ff @(posedge clk or negedge reset)
    if (!reset) mdCnt <= 4'd0;
    else if (md_start_e) mdCnt <= md_kind_e ? 4'd10 : 4'd5;
    else if (mdCnt != 4'd0) mdCnt <= mdCnt - 4'd1;

  // md_start_e is a live input, so mask it while reset holds the unit idle.
  assign md_busy = reset & (md_start_e | (mdCnt != 4'd0));
  assign mdStall = md_use_d & md_busy;
`else
  logic unusedMd;
  assign unusedMd = ^{md_use_d, md_start_e, md_kind_e};
  assign md_busy  = 1'b0;
  assign mdStall  = 1'b0;
`endif

  assign stall  = gprHaz | mdStall;
  assign en_pc  = ~stall;
  assign en_d   = ~stall;
  assign clr_e  = stall;
  assign tnew_e = tagE.tnew;
  assign tnew_m = tagM.tnew;
endmodule

// File: tb/tb_stall_unit.sv
// tb_stall_unit: scoreboard bench for stall_unit; an independent tag model predicts every cycle.
module tb_stall_unit;
  logic       clk = 1'b0, reset = 1'b0;
  logic [4:0] rs_d, rt_d, wdst_d;
  logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic       md_use_d, md_start_e, md_kind_e;
  logic       stall, en_pc, en_d, clr_e, md_busy;
  logic [1:0] tnew_e, tnew_m;

  stall_unit dut (
    .clk(clk), .reset(reset), .rs_d(rs_d), .rt_d(rt_d), .tuse_rs_d(tuse_rs_d),
    .tuse_rt_d(tuse_rt_d), .wdst_d(wdst_d), .tnew_d(tnew_d), .md_use_d(md_use_d),
    .md_start_e(md_start_e), .md_kind_e(md_kind_e), .stall(stall), .en_pc(en_pc),
    .en_d(en_d), .clr_e(clr_e), .md_busy(md_busy), .tnew_e(tnew_e), .tnew_m(tnew_m)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       stall, enPc, enD, clrE, mdBusy;
    logic [1:0] tnewE, tnewM;
  } outs_t;

  outs_t      expQ[$];
  logic [4:0] refDst[3];
  logic [1:0] refTnew[3];
  int         refCnt;
  int         vectors = 0, miscompares = 0;
  logic       lastStall, lastBusy;
  int         n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refClear();
    for (int i = 0; i < 3; i++) begin
      refDst[i]  = 5'd0;
      refTnew[i] = 2'd0;
    end
    refCnt = 0;
  endtask

  function automatic outs_t predict();
    outs_t o;
    logic haz, busy;
    haz  = 1'b0;
    busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (refDst[i] != 0 && refDst[i] == rs_d && tuse_rs_d < refTnew[i]) haz = 1'b1;
      if (refDst[i] != 0 && refDst[i] == rt_d && tuse_rt_d < refTnew[i]) haz = 1'b1;
    end
`ifdef MD_HAZARD_EN
    busy = reset && (md_start_e || refCnt != 0);
    if (md_use_d && busy) haz = 1'b1;
`endif
    o.stall  = haz;
    o.enPc   = !haz;
    o.enD    = !haz;
    o.clrE   = haz;
    o.mdBusy = busy;
    o.tnewE  = refTnew[0];
    o.tnewM  = refTnew[1];
    return o;
  endfunction

  task automatic refAdvance(input logic stl);
    for (int i = 2; i > 0; i--) begin
      refDst[i]  = refDst[i-1];
      refTnew[i] = (refTnew[i-1] > 0) ? refTnew[i-1] - 2'd1 : 2'd0;
    end
    refDst[0]  = stl ? 5'd0 : wdst_d;
    refTnew[0] = stl ? 2'd0 : tnew_d;
    if (md_start_e) refCnt = md_kind_e ? 10 : 5;
    else if (refCnt > 0) refCnt--;
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input string tag);
    outs_t e, g;
    if (!reset) refClear();
    e = predict();
    expQ.push_back(e);
    #1;
    g = {stall, en_pc, en_d, clr_e, md_busy, tnew_e, tnew_m};
    lastStall = stall;
    lastBusy  = md_busy;
    check(tag, 32'(g), 32'(expQ.pop_front()));
    @(posedge clk);
    if (reset) refAdvance(e.stall);
    else refClear();
    @(negedge clk);
  endtask

  task automatic drv(input logic [4:0] rs, input logic [1:0] tr, input logic [4:0] rt,
                     input logic [1:0] tt, input logic [4:0] wd, input logic [1:0] tn,
                     input logic mu, input logic ms, input logic mk);
    rs_d = rs; tuse_rs_d = tr; rt_d = rt; tuse_rt_d = tt;
    wdst_d = wd; tnew_d = tn; md_use_d = mu; md_start_e = ms; md_kind_e = mk;
  endtask

  task automatic nop();
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (4) step("drain");
  endtask

  // Steps the held D instruction until it issues; cnt = number of stalled cycles.
  task automatic runHeld(input string tag, output int cnt);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(tag);
      if (!lastStall) return;
      cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    refClear();
    drv(5'd8, 2'd0, 5'd8, 2'd0, 5'd8, 2'd2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    repeat (3) step("rst_hold");
    check("rst_stall", stall, 0);
    check("rst_en_pc", en_pc, 1);
    check("rst_clr_e", clr_e, 0);
    check("rst_tnew_e", tnew_e, 0);
    check("rst_md_busy", md_busy, 0);
    nop();
    reset = 1'b1;
    step("post_rst");

    // load-use: lw $8 then add rs=$8
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0);
    step("lw8");
    drv(5'd8, 2'd1, 5'd0, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
    step("lu1");
    check("lu_stall", lastStall, 1);
    check("lu_bubble_tnew_e", tnew_e, 0);
    step("lu2");
    check("lu_release", lastStall, 0);
    drain();

    // branch after load: 2 stalls
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
    step("lw9");
    drv(5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    runHeld("beq_lw", n);
    check("beq_lw_cycles", n, 2);
    drain();

    // branch after ALU: 1 stall
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0);
    step("alu9");
    drv(5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    runHeld("beq_alu", n);
    check("beq_alu_cycles", n, 1);
    drain();

    // writes to $0 never hazard
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    step("lw0");
    drv(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    runHeld("use0", n);
    check("use0_cycles", n, 0);
    drain();

    // store data after ALU: no stall
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
    step("alu10");
    drv(5'd0, 2'd3, 5'd10, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    runHeld("sw", n);
    check("sw_cycles", n, 0);
    drain();

    // rt hazard: lw $11 then ALU rt=$11
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd11, 2'd2, 1'b0, 1'b0, 1'b0);
    step("lw11");
    drv(5'd0, 2'd3, 5'd11, 2'd1, 5'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    runHeld("rt_lu", n);
    check("rt_lu_cycles", n, 1);
    drain();

    // younger non-hazard match in E must not mask older load in M
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 2'd2, 1'b0, 1'b0, 1'b0);
    step("lw12");
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd12, 2'd0, 1'b0, 1'b0, 1'b0);
    step("jal12");
    drv(5'd12, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    runHeld("mask", n);
    check("mask_cycles", n, 1);
    drain();

`ifdef MD_HAZARD_EN
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    step("div_start");
    check("div_start_busy", lastBusy, 1);
    md_start_e = 1'b0;
    runHeld("div", n);
    check("div_cycles", n + 1, 11);
    drain();
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    step("mult_start");
    md_start_e = 1'b0;
    runHeld("mult", n);
    check("mult_cycles", n + 1, 6);
    drain();
    // abort a div at count 7 with an mflo waiting
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd13, 2'd2, 1'b0, 1'b1, 1'b1);
    step("div_abort_start");
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) step("div_count");
    #1;
    check("md_abort_pre", stall, 1);
    reset = 1'b0;
    #1;
    check("md_abort_busy", md_busy, 0);
    check("md_abort_stall", stall, 0);
    @(negedge clk);
    step("md_abort_hold");
    nop();
    reset = 1'b1;
    step("md_abort_after");
    drain();
`else
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    step("md_off");
    check("md_off_busy", lastBusy, 0);
    check("md_off_stall", lastStall, 0);
    drain();
`endif

    // reset mid load-use stall
    drv(5'd0, 2'd3, 5'd0, 2'd3, 5'd13, 2'd2, 1'b0, 1'b0, 1'b0);
    step("lw13");
    drv(5'd13, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    step("abort_pre");
    check("abort_pre_stall", lastStall, 1);
    reset = 1'b0;
    step("abort");
    check("abort_stall", lastStall, 0);
    nop();
    reset = 1'b1;
    step("abort_after");
    check("abort_tnew_e", tnew_e, 0);
    check("abort_tnew_m", tnew_m, 0);

    // random traffic against the model
    for (int k = 0; k < 300; k++) begin
      drv(5'($urandom_range(0, 4)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 4)),
          2'($urandom_range(0, 3)), 5'($urandom_range(0, 4)), 2'($urandom_range(0, 2)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stall_unit.md
STALL_UNIT -- requirements
Module: stall_unit

Interface
REQ-001 Port clk input 1: sole clock; all state updates on its rising edge.
REQ-002 Port reset input 1: asynchronous, active-low reset; 0 clears all state immediately.
REQ-003 Port rs_d input 5: rs field of the instruction in D.
REQ-004 Port rt_d input 5: rt field of the instruction in D.
REQ-005 Port tuse_rs_d input 2: cycles before the D instruction consumes rs (0 = branch/jr, 1 = ALU, 3 = not used).
REQ-006 Port tuse_rt_d input 2: same for rt (2 = store data, 3 = not used).
REQ-007 Port wdst_d input 5: destination GPR of the D instruction (0 = no write).
REQ-008 Port tnew_d input 2: cycles after entering E until its result is forwardable (0 = PC+8, 1 = ALU, 2 = load).
REQ-009 Port md_use_d input 1: D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 Port md_start_e input 1: a mult/div occupies E this cycle.
REQ-011 Port md_kind_e input 1: 0 = mult, 1 = div; valid with md_start_e.
REQ-012 Port stall output 1: freeze the F/D registers and insert a bubble into E.
REQ-013 Port en_pc output 1: PC write enable, equal to ~stall.
REQ-014 Port en_d output 1: D pipeline-register enable, equal to ~stall.
REQ-015 Port clr_e output 1: E pipeline-register clear, equal to stall.
REQ-016 Port md_busy output 1: the mult/div unit is occupied.
REQ-017 Ports tnew_e, tnew_m outputs 2 each: remaining Tnew of the tags in E and M, used to qualify forwarding.

Function
REQ-018 Three tag registers (E, M, W) SHALL each hold {dst[4:0], tnew[1:0]}.
REQ-019 Each clock, the E tag SHALL load {wdst_d, tnew_d} when stall=0 and {0, 0} (bubble) when stall=1.
REQ-020 Each clock, M SHALL load {E.dst, sat(E.tnew-1)} and W SHALL load {M.dst, sat(M.tnew-1)}; sat clamps at 0 and never wraps.
REQ-021 A stage X SHALL hazard rs when X.dst==rs_d, rs_d!=0, and tuse_rs_d < X.tnew; rt uses rt_d and tuse_rt_d the same way.
REQ-022 tuse=3 SHALL never hazard; dst=0 SHALL never hazard.
REQ-023 stall SHALL be combinational: the OR of all rs/rt hazards over E, M and W, OR'd with the mult/div stall.
REQ-024 A matching tag in a younger stage SHALL NOT mask a hazard in an older stage; any hazard stalls.
REQ-025 A consecutive load-use pair (tnew_d=2, then a consumer with tuse=1) SHALL stall exactly 1 cycle; with a branch consumer (tuse=0), exactly 2 cycles.

Reset
REQ-026 While reset=0, all tag registers SHALL be {0, 0} and the md counter 0; therefore stall=0, en_pc=en_d=1, clr_e=0, md_busy=0 and tnew_e=tnew_m=0.
REQ-027 Reset asserted mid-stall or mid mult/div SHALL abort it immediately; no state survives.

Configuration
REQ-028 Macro MD_HAZARD_EN SHALL gate the mult/div busy tracking.
REQ-029 With MD_HAZARD_EN defined: a 4-bit counter SHALL load 5 (mult) or 10 (div) on md_start_e.
REQ-030 With MD_HAZARD_EN defined: otherwise the counter SHALL decrement to 0 and hold there.
REQ-031 With MD_HAZARD_EN defined: md_busy = md_start_e | (count!=0), and mult/div stall = md_use_d & md_busy.
REQ-032 With MD_HAZARD_EN defined: md_start_e while count!=0 SHALL reload the counter.
REQ-033 Without MD_HAZARD_EN: no counter is instantiated, md_busy=0, md_use_d/md_start_e/md_kind_e are ignored, and stall comes from GPR hazards only.

Verification
REQ-034 Reset test: hold reset=0 with arbitrary inputs -> stall=0, en_pc=1, clr_e=0, tnew_e=0.
REQ-035 Load-use test: D=lw $8 (wdst=8, tnew=2), then D=add rs=8 (tuse=1) -> stall=1 for 1 cycle, E bubble with tnew_e=0; next cycle stall=0.
REQ-036 Branch test: lw $9, then beq rs=9 (tuse=0) -> stall for 2 cycles; ALU $9 then beq -> stall for 1 cycle.
REQ-037 No-hazard test: add $0 or wdst=0, then a consumer of $0 -> stall=0; store rt matching an ALU dst in E (tuse=2, tnew=1) -> stall=0.
REQ-038 Mult/div test (MD_HAZARD_EN): div enters E (md_kind_e=1), then D=mflo -> md_busy=1 and stall=1 for 11 cycles (start + 10), released when count reaches 0; mult gives 6.
REQ-039 Reset-abort test: assert reset during a div count of 7 -> md_busy=0 and stall=0 immediately; the next clock shows no residual tags.
